// File: rtl/cpu_step_controller.sv
// cpu_step_controller: turns prescaler tick edges into CPU enable strobes with run/halt/step/breakpoint control
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ADDR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
  state_t state, state_n;
  logic tick_d, tick_rise, sync1, sync2, db, db_d, step_press;
  logic skip_bp, skip_bp_n, bp_hit_n, issue, cpu_en_q;
  logic [DW-1:0] db_cnt;
  assign tick_rise = tick_in & ~tick_d;
  assign step_press = db & ~db_d;
  assign halted = state == HALT;
  // a strobe already registered is masked while reset is high so reset stops the CPU immediately
  assign cpu_en = cpu_en_q & ~reset;
  // button filter: the counter only advances while the synchronised level disagrees with the accepted one
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db <= 1'b0;
      db_d <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      db_d <= db;
      if (sync2 == db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db <= sync2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  // control state, strobe and executed-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HALT;
      tick_d <= 1'b0;
      skip_bp <= 1'b0;
      bp_hit <= 1'b0;
      cpu_en_q <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_n;
      tick_d <= tick_in;
      skip_bp <= skip_bp_n;
      bp_hit <= bp_hit_n;
      cpu_en_q <= issue;
      cycle_count <= cycle_count + CNT_W'(issue);
    end
  end
  // next state: halt beats everything, run beats step; skip_bp lets a resume step off a breakpoint PC
  always_comb begin
    state_n = state;
    skip_bp_n = skip_bp;
    bp_hit_n = bp_hit;
    issue = 1'b0;
    case (state)
      HALT:
        if (!halt_req && (run_req || step_press)) begin
          state_n = run_req ? RUN : STEP;
          skip_bp_n = 1'b1;
          bp_hit_n = 1'b0;
        end
      RUN:
        if (halt_req) state_n = HALT;
        else if (tick_rise && bp_en && pc == bp_addr && !skip_bp) begin
          state_n = HALT;
          bp_hit_n = 1'b1;
        end else if (tick_rise) begin
          issue = 1'b1;
          skip_bp_n = 1'b0;
        end
      STEP:
        if (halt_req) state_n = HALT;
        else if (tick_rise) begin
          issue = 1'b1;
          state_n = HALT;
        end
      default: state_n = HALT;
    endcase
  end
endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller: directed checks of run, halt, debounced step, breakpoint, counter wrap and reset
module tb_cpu_step_controller;
  logic clk = 1'b0, reset = 1'b1, tick_in = 1'b0, run_req = 1'b0, halt_req = 1'b0;
  logic step_btn = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = '0, pc = '0;
  logic cpu_en, halted, bp_hit;
  logic [3:0] cycle_count;
  int checks = 0, errors = 0, pulses = 0, p0;
  cpu_step_controller #(.DEBOUNCE_CYCLES(4), .ADDR_W(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run_req(run_req), .halt_req(halt_req),
    .step_btn(step_btn), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (cpu_en) pulses++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clk1(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_tick(input string tag, input logic exp_en);
    tick_in = 1'b1;
    clk1();
    chk(tag, 32'(cpu_en), 32'(exp_en));
    clk1();
    chk({tag, "_next"}, 32'(cpu_en), 0);
    clk1(2);
    tick_in = 1'b0;
    clk1(4);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    clk1();
    reset = 1'b0;
  endtask
  task automatic pulse_run();
    run_req = 1'b1;
    clk1();
    run_req = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_en", 32'(cpu_en), 0);
    chk("rst_halted", 32'(halted), 1);
    chk("rst_bp", 32'(bp_hit), 0);
    chk("rst_cnt", 32'(cycle_count), 0);
    p0 = pulses;
    pulse_run();
    chk("run_halted", 32'(halted), 0);
    for (int i = 0; i < 10; i++) run_tick("fr_en", 1'b1);
    chk("fr_pulses", 32'(pulses - p0), 10);
    chk("fr_cnt", 32'(cycle_count), 10);
    chk("fr_halted", 32'(halted), 0);
    tick_in = 1'b1;
    halt_req = 1'b1;
    clk1();
    halt_req = 1'b0;
    chk("hp_en", 32'(cpu_en), 0);
    chk("hp_halted", 32'(halted), 1);
    chk("hp_cnt", 32'(cycle_count), 10);
    tick_in = 1'b0;
    clk1(3);
    run_req = 1'b1;
    halt_req = 1'b1;
    clk1();
    run_req = 1'b0;
    halt_req = 1'b0;
    chk("hp_both", 32'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 4) < 2;
      clk1();
    end
    step_btn = 1'b1;
    clk1(12);
    chk("st_wait", 32'(halted), 0);
    run_tick("st_en", 1'b1);
    chk("st_halted", 32'(halted), 1);
    chk("st_cnt", 32'(cycle_count), 11);
    run_tick("st_again", 1'b0);
    chk("st_cnt2", 32'(cycle_count), 11);
    step_btn = 1'b0;
    clk1(10);
    chk("st_release", 32'(halted), 1);
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h40;
    pc = 32'h30;
    pulse_run();
    for (int i = 0; i < 5; i++) begin
      run_tick("bp_en", pc != 32'h40);
      if (pc != 32'h40) pc += 4;
    end
    chk("bp_pc", pc, 32'h40);
    chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_halted", 32'(halted), 1);
    chk("bp_cnt", 32'(cycle_count), 4);
    pulse_run();
    chk("bp_clear", 32'(bp_hit), 0);
    run_tick("bp_skip", 1'b1);
    chk("bp_cnt2", 32'(cycle_count), 5);
    pc = 32'h40;
    run_tick("bp_rehit", 1'b0);
    chk("bp_rehit_flag", 32'(bp_hit), 1);
    do_reset();
    chk("rst_bp2", 32'(bp_hit), 0);
    chk("rst_cnt2", 32'(cycle_count), 0);
    bp_en = 1'b0;
    pulse_run();
    for (int i = 0; i < 17; i++) run_tick("wr_en", 1'b1);
    chk("wr_cnt", 32'(cycle_count), 1);
    tick_in = 1'b1;
    clk1();
    chk("mr_pre", 32'(cpu_en), 1);
    reset = 1'b1;
    #1;
    chk("mr_en_in_reset", 32'(cpu_en), 0);
    clk1();
    reset = 1'b0;
    chk("mr_en", 32'(cpu_en), 0);
    chk("mr_halted", 32'(halted), 1);
    chk("mr_cnt", 32'(cycle_count), 0);
    chk("mr_bp", 32'(bp_hit), 0);
    clk1();
    chk("mr_en_after", 32'(cpu_en), 0);
    tick_in = 1'b0;
    clk1(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
